syscall_unit: RTL and testbench
===============================

Name: syscall_unit

Overview:
- Pipelined, clocked successor to the combinational syscall monitor.
- Decodes SYSCALL in the execute stage and stalls the pipeline while a service runs.
- Queues console output in a parametrised FIFO drained by a valid/ready console sink.
- Fetches print-string bytes over a data-memory read port; implements orderly exit (drain, then halt) and flags unknown service codes.

Parameters:
- DATA_W, 32, width of v0/a0/console data and memory address.
- FIFO_DEPTH, 8, console FIFO entries; power of two, ≥2.
- MAX_STR_LEN, 64, maximum bytes emitted per print-string before forced termination.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- syscall_valid  in  1  execute stage holds a valid instruction this cycle.
- instruction  in  32  instruction word in execute stage.
- v0  in  DATA_W  service code.
- a0  in  DATA_W  argument: value, char, or string address.
- stall  out  1  freeze pipeline.
- mem_req  out  1  byte read request.
- mem_addr  out  DATA_W  byte address.
- mem_ack  in  1  read data valid, any latency ≥1.
- mem_rdata  in  8  byte returned.
- con_valid  out  1  FIFO head valid.
- con_type  out  1  0 = signed integer, 1 = character.
- con_data  out  DATA_W  payload.
- con_ready  in  1  sink accepts head.
- halted  out  1  exit completed.
- bad_syscall  out  1  sticky unknown-service flag.

Behaviour:
- Reset values:
  - All outputs 0.
  - FIFO empty, state IDLE.
  - Reset asserted mid-operation aborts the service, discards the FIFO and cancels any outstanding mem_req; a late mem_ack is ignored.
- Decode:
  - is_sys = syscall_valid & instruction[31:26]==0 & instruction[5:0]==6'h0C.
  - Accepted only in IDLE; v0 and a0 are latched on the accept edge.
- stall = (state != IDLE) | (state==IDLE & is_sys). Combinational, so the accepting cycle is already stalled.
- States: IDLE, EXEC, STR_REQ, STR_WAIT, DRAIN, HALT.
- EXEC dispatch on latched v0:
  - 1: push {0, a0}, then IDLE.
  - 11: push {1, zero-extended a0[7:0]}, then IDLE.
  - 4: ptr = a0, len = 0, go to STR_REQ.
  - 10: go to DRAIN.
  - Other: set bad_syscall, then IDLE.
- Push blocking: a push blocks (state holds) while the FIFO is full. A push is permitted when full if a pop occurs in the same cycle.
- Print-integer timing: accept at edge N, EXEC in cycle N+1, con_valid high from cycle N+2, stall low in cycle N+2 when the FIFO is not full.
- STR_REQ: mem_req=1, mem_addr=ptr; go to STR_WAIT. mem_req holds until mem_ack.
- STR_WAIT, on mem_ack:
  - Byte 0: go to IDLE.
  - Otherwise push {1, byte}, ptr+1, len+1. If len+1 == MAX_STR_LEN go to IDLE, else STR_REQ.
  - A full FIFO holds STR_WAIT with the byte captured.
- DRAIN: wait until the FIFO is empty, then go to HALT. In HALT, halted=1 and stall=1 until reset; is_sys is ignored.
- FIFO:
  - Registered head; pop on con_valid & con_ready; pointers wrap modulo FIFO_DEPTH.
  - con_data/con_type stable while con_valid & !con_ready.
- ptr arithmetic is DATA_W-bit and wraps at 2^DATA_W.
- bad_syscall clears only on reset.

Optional Feature:
SYSCALL_STATS_EN:
- Defined: adds outputs cycle_count, instr_count and syscall_count, each 32 bit, reset to 0, saturating at all-ones.
  - cycle_count increments every cycle while !halted.
  - instr_count increments every cycle with syscall_valid & !stall.
  - syscall_count increments on each accepted syscall.
  - On entering HALT, the unit prints the three counters via $display once (simulation only).
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Print integer: v0=1, a0=32'hFFFF_FFFB, con_ready=1 → one entry {type 0, data -5}; con_valid first high in cycle N+2; stall high in cycles N and N+1 only.
- Print string with memory back-pressure: v0=4, a0=0x100, memory "Hi\0" with 3-cycle ack, con_ready=0 → two char entries 0x48, 0x69, then IDLE. FIFO_DEPTH=2 holds; con_valid stays high with data stable until ready.
- Overlong string: no terminator, MAX_STR_LEN=64 → exactly 64 entries, mem_req never issued for ptr a0+64.
- Exit with pending output: 3 entries queued, then v0=10 → halted stays 0 until the third pop; then halted=1, stall=1 permanently; further syscalls ignored.
- Bad service and non-syscall: v0=99 → bad_syscall=1 sticky, no FIFO push. An instruction with funct 0x0C but a non-zero opcode → no stall, no action.
- Async reset mid-string: reset asserted while in STR_WAIT → outputs 0 immediately without a clock edge; a subsequent mem_ack produces no push.

Source files
------------

// File: rtl/syscall_unit.sv
// syscall_unit: pipelined SYSCALL service unit.
// Decodes SYSCALL in execute, stalls the pipeline while a service runs, queues
// console output in a FIFO drained by a valid/ready sink, fetches print-string
// bytes over a byte read port, and implements exit (drain, then halt).
// Optional build macro SYSCALL_STATS_EN adds saturating cycle/instruction/
// syscall counters as extra output ports.
//
// state      | meaning
// -----------+---------------------------------------------------------
// S_IDLE     | waiting for a SYSCALL in execute
// S_EXEC     | dispatch on latched v0; print-int/print-char push here
// S_STR_REQ  | issue byte read at ptr
// S_STR_WAIT | wait for mem_ack; holds a captured byte while FIFO full
// S_DRAIN    | exit requested, waiting for console FIFO to empty
// S_HALT     | exit complete; stalled until reset
module syscall_unit #(
  parameter int DATA_W      = 32,
  parameter int FIFO_DEPTH  = 8,
  parameter int MAX_STR_LEN = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              syscall_valid,
  input  logic [31:0]       instruction,
  input  logic [DATA_W-1:0] v0,
  input  logic [DATA_W-1:0] a0,
  output logic              stall,
  output logic              mem_req,
  output logic [DATA_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
  output logic              con_valid,
  output logic              con_type,
  output logic [DATA_W-1:0] con_data,
  input  logic              con_ready,
  output logic              halted,
  output logic              bad_syscall
`ifdef SYSCALL_STATS_EN
  ,
  output logic [31:0]       cycle_count,
  output logic [31:0]       instr_count,
  output logic [31:0]       syscall_count
`endif
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int LEN_W = $clog2(MAX_STR_LEN + 1);

  localparam logic [DATA_W-1:0] SVC_PRINT_INT  = DATA_W'(1);
  localparam logic [DATA_W-1:0] SVC_PRINT_STR  = DATA_W'(4);
  localparam logic [DATA_W-1:0] SVC_EXIT       = DATA_W'(10);
  localparam logic [DATA_W-1:0] SVC_PRINT_CHAR = DATA_W'(11);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_STR_REQ,
    S_STR_WAIT,
    S_DRAIN,
    S_HALT
  } state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] v0_q, a0_q;
  logic [DATA_W-1:0] ptr_q, ptr_nxt;
  logic [LEN_W-1:0]  len_q, len_nxt, len_inc;
  logic [7:0]        byte_q, byte_nxt;
  logic              byte_held, byte_held_nxt;
  logic              bad_q, bad_nxt;

  logic              is_sys;
  logic              accept;
  logic              push;
  logic              push_type;
  logic [DATA_W-1:0] push_data;
  logic              pop;
  logic              full;
  logic              can_push;

  logic              fifo_type [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;

  // Only opcode and funct identify a SYSCALL; the middle bits are don't-care.
  logic unused_instr_bits;
  assign unused_instr_bits = ^instruction[25:6];

  assign is_sys = syscall_valid & (instruction[31:26] == 6'd0) & (instruction[5:0] == 6'h0C);
  assign accept = (state == S_IDLE) & is_sys;

  // Gated by reset so every output reads 0 while reset is held.
  assign stall  = ~reset & ((state != S_IDLE) | is_sys);
  assign halted = (state == S_HALT);
  assign bad_syscall = bad_q;
  assign mem_addr    = ptr_q;

  assign con_valid = (count != '0);
  assign con_type  = con_valid ? fifo_type[rd_ptr] : 1'b0;
  assign con_data  = con_valid ? fifo_data[rd_ptr] : '0;

  assign pop      = con_valid & con_ready;
  assign full     = (count == CNT_W'(FIFO_DEPTH));
  assign can_push = ~full | pop;
  assign len_inc  = len_q + LEN_W'(1);

  // State and service-context registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      ptr_q     <= '0;
      len_q     <= '0;
      byte_q    <= '0;
      byte_held <= 1'b0;
      bad_q     <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr_q     <= ptr_nxt;
      len_q     <= len_nxt;
      byte_q    <= byte_nxt;
      byte_held <= byte_held_nxt;
      bad_q     <= bad_nxt;
    end
  end

  // Latch service code and argument on the accept edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v0_q <= '0;
      a0_q <= '0;
    end else if (accept) begin
      v0_q <= v0;
      a0_q <= a0;
    end
  end

  // Next-state, FIFO push request and memory request.
  always_comb begin
    state_nxt     = state;
    ptr_nxt       = ptr_q;
    len_nxt       = len_q;
    byte_nxt      = byte_q;
    byte_held_nxt = byte_held;
    bad_nxt       = bad_q;
    push          = 1'b0;
    push_type     = 1'b0;
    push_data     = '0;
    mem_req       = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (is_sys) state_nxt = S_EXEC;
      end
      S_EXEC: begin
        if (v0_q == SVC_PRINT_INT) begin
          push_type = 1'b0;
          push_data = a0_q;
          if (can_push) begin
            push      = 1'b1;
            state_nxt = S_IDLE;
          end
        end else if (v0_q == SVC_PRINT_CHAR) begin
          push_type = 1'b1;
          push_data = {{(DATA_W-8){1'b0}}, a0_q[7:0]};
          if (can_push) begin
            push      = 1'b1;
            state_nxt = S_IDLE;
          end
        end else if (v0_q == SVC_PRINT_STR) begin
          ptr_nxt       = a0_q;
          len_nxt       = '0;
          byte_held_nxt = 1'b0;
          state_nxt     = S_STR_REQ;
        end else if (v0_q == SVC_EXIT) begin
          state_nxt = S_DRAIN;
        end else begin
          bad_nxt   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_STR_REQ: begin
        mem_req   = 1'b1;
        state_nxt = S_STR_WAIT;
      end
      S_STR_WAIT: begin
        push_type = 1'b1;
        if (byte_held) begin
          // Byte already fetched; retry the push without re-reading memory.
          push_data = {{(DATA_W-8){1'b0}}, byte_q};
          if (can_push) begin
            push          = 1'b1;
            byte_held_nxt = 1'b0;
            ptr_nxt       = ptr_q + DATA_W'(1);
            len_nxt       = len_inc;
            state_nxt     = (len_inc == LEN_W'(MAX_STR_LEN)) ? S_IDLE : S_STR_REQ;
          end
        end else begin
          mem_req   = 1'b1;
          push_data = {{(DATA_W-8){1'b0}}, mem_rdata};
          if (mem_ack) begin
            if (mem_rdata == 8'd0) begin
              state_nxt = S_IDLE;
            end else if (can_push) begin
              push      = 1'b1;
              ptr_nxt   = ptr_q + DATA_W'(1);
              len_nxt   = len_inc;
              state_nxt = (len_inc == LEN_W'(MAX_STR_LEN)) ? S_IDLE : S_STR_REQ;
            end else begin
              byte_nxt      = mem_rdata;
              byte_held_nxt = 1'b1;
            end
          end
        end
      end
      S_DRAIN: begin
        if (count == '0) state_nxt = S_HALT;
      end
      S_HALT: begin
        state_nxt = S_HALT;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push & ~pop)      count <= count + CNT_W'(1);
      else if (~push & pop) count <= count - CNT_W'(1);
    end
  end

  // FIFO storage; contents are don't-care until written, head is gated by con_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_type[wr_ptr] <= push_type;
      fifo_data[wr_ptr] <= push_data;
    end
  end

`ifdef SYSCALL_STATS_EN
  // Saturating activity counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_count   <= '0;
      instr_count   <= '0;
      syscall_count <= '0;
    end else begin
      if (!halted && cycle_count != '1) cycle_count <= cycle_count + 32'd1;
      if (syscall_valid && !stall && instr_count != '1) instr_count <= instr_count + 32'd1;
      if (accept && syscall_count != '1) syscall_count <= syscall_count + 32'd1;
    end
  end

`ifndef SYNTHESIS
  // Report the counters once on the transition into HALT.
  always @(posedge clk) begin
    if (!reset && state == S_DRAIN && state_nxt == S_HALT)
      $display("syscall_unit stats: cycles=%0d instrs=%0d syscalls=%0d",
               cycle_count, instr_count, syscall_count);
  end
`endif
`endif

endmodule

// File: tb/tb_syscall_unit.sv
// Self-checking bench for syscall_unit: console scoreboard built from the
// service semantics, memory responder with configurable ack latency, and
// directed scenarios with literal expectations.
module tb_syscall_unit;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int MAXL  = 64;
  localparam logic [31:0] SYS_W = 32'h0000_000C;

  logic          clk = 1'b0;
  logic          reset;
  logic          syscall_valid;
  logic [31:0]   instruction;
  logic [DW-1:0] v0, a0;
  logic          stall, mem_req, mem_ack;
  logic [DW-1:0] mem_addr;
  logic [7:0]    mem_rdata;
  logic          con_valid, con_type, con_ready;
  logic [DW-1:0] con_data;
  logic          halted, bad_syscall;
`ifdef SYSCALL_STATS_EN
  logic [31:0]   cycle_count, instr_count, syscall_count;
`endif

  always #5 clk = ~clk;

  syscall_unit #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .MAX_STR_LEN(MAXL)) dut (
    .clk(clk), .reset(reset), .syscall_valid(syscall_valid), .instruction(instruction),
    .v0(v0), .a0(a0), .stall(stall), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .con_valid(con_valid), .con_type(con_type),
    .con_data(con_data), .con_ready(con_ready), .halted(halted), .bad_syscall(bad_syscall)
`ifdef SYSCALL_STATS_EN
    , .cycle_count(cycle_count), .instr_count(instr_count), .syscall_count(syscall_count)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [32:0]  exp_q[$];        // {type, data} in emission order
  logic [7:0]   mem_arr [0:1023];
  logic [31:0]  str_base = '0;
  int           str_ack0 = 0;
  int           ack_total = 0;   // written only by the compare process
  int           n_pops = 0;      // written only by the compare process
  bit           exp_bad = 1'b0;
  bit           model_halted = 1'b0;

  // What a service must emit, from the service definitions alone.
  task automatic model_syscall(input logic [31:0] code, input logic [31:0] arg);
    if (model_halted) return;
    case (code)
      32'd1:  exp_q.push_back({1'b0, arg});
      32'd11: exp_q.push_back({1'b1, 24'd0, arg[7:0]});
      32'd4: begin
        str_base = arg;
        str_ack0 = ack_total;
        for (int i = 0; i < MAXL; i++) begin
          logic [7:0] b;
          b = mem_arr[(arg + i) & 32'h3FF];
          if (b == 8'd0) break;
          exp_q.push_back({1'b1, 24'd0, b});
        end
      end
      32'd10: ;
      default: exp_bad = 1'b1;
    endcase
  endtask

  // ---------------- memory responder ----------------
  int   mem_lat = 1;
  bit   mem_manual = 1'b0;
  logic manual_ack = 1'b0;
  logic [7:0] manual_data = 8'h00;
  int   lat_cnt = 0;

  always begin
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
    if (mem_manual) begin
      mem_ack   = manual_ack;
      mem_rdata = manual_data;
      lat_cnt   = 0;
    end else if (mem_req && !reset) begin
      if (lat_cnt >= mem_lat) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_arr[mem_addr[9:0]];
        lat_cnt   = 0;
      end else begin
        lat_cnt++;
      end
    end else begin
      lat_cnt = 0;
    end
  end

  // ---------------- per-cycle compare ----------------
  bit          prev_hold = 1'b0;
  logic        prev_type;
  logic [31:0] prev_data;

  always @(negedge clk) begin
    if (!reset) begin
      if (prev_hold) begin
        check("hold_valid", con_valid, 1);
        check("hold_data", {con_type, con_data}, {prev_type, prev_data});
      end
      if (con_valid && con_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL pop_unexpected: got 0x%0h, required no entry", {con_type, con_data});
        end else begin
          check("pop_entry", {con_type, con_data}, exp_q.pop_front());
        end
        n_pops++;
      end
      if (mem_req) begin
        check("mem_addr", mem_addr, str_base + (ack_total - str_ack0));
        check("str_limit", ((ack_total - str_ack0) < MAXL), 1);
        if (mem_ack) ack_total++;
      end
      if (halted) begin
        check("halt_stall", stall, 1);
        check("halt_empty", con_valid, 0);
      end
      if (!exp_bad) check("bad_spurious", bad_syscall, 0);
      prev_hold = con_valid && !con_ready;
      prev_type = con_type;
      prev_data = con_data;
    end else begin
      prev_hold = 1'b0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_idle(input string name);
    int k;
    for (k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (!stall) break;
    end
    if (k == 1000) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: got stall stuck high, required return to idle", name);
    end
  endtask

  task automatic wait_drain(input string name);
    int k;
    for (k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    if (k == 1000) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: got %0d entries left, required 0", name, exp_q.size());
    end
  endtask

  task automatic issue(input logic [31:0] code, input logic [31:0] arg, input bit do_wait);
    @(posedge clk); #1;
    syscall_valid = 1'b1;
    instruction   = SYS_W;
    v0            = code;
    a0            = arg;
    @(posedge clk); #1;
    syscall_valid = 1'b0;
    model_syscall(code, arg);
    if (do_wait) wait_idle("issue_idle");
  endtask

  task automatic set_ready(input logic r);
    @(posedge clk); #1;
    con_ready = r;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    reset = 1'b1; syscall_valid = 1'b0; instruction = '0; v0 = '0; a0 = '0;
    con_ready = 1'b0; mem_rdata = '0; mem_ack = 1'b0;
    for (int i = 0; i < 1024; i++) mem_arr[i] = 8'h00;
    mem_arr[10'h100] = 8'h48; mem_arr[10'h101] = 8'h69; mem_arr[10'h102] = 8'h00;
    mem_arr[10'h200] = "H"; mem_arr[10'h201] = "e"; mem_arr[10'h202] = "l";
    mem_arr[10'h203] = "l"; mem_arr[10'h204] = "o"; mem_arr[10'h205] = 8'h00;
    for (int i = 10'h300; i < 10'h3F0; i++) mem_arr[i] = 8'h41 + 8'(i % 26);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", {stall, mem_req, con_valid, con_type, halted, bad_syscall}, 6'b0);
    check("rst_data", {mem_addr, con_data}, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_stall", stall, 0);

    // Print integer -5: exact cycle timing
    con_ready = 1'b1;
    @(posedge clk); #1;
    syscall_valid = 1'b1; instruction = SYS_W; v0 = 32'd1; a0 = 32'hFFFF_FFFB;
    @(negedge clk);
    check("int_stall_N", stall, 1);
    check("int_valid_N", con_valid, 0);
    @(posedge clk); #1;
    syscall_valid = 1'b0;
    model_syscall(32'd1, 32'hFFFF_FFFB);
    @(negedge clk);
    check("int_stall_N1", stall, 1);
    check("int_valid_N1", con_valid, 0);
    @(negedge clk);
    check("int_valid_N2", con_valid, 1);
    check("int_stall_N2", stall, 0);
    check("int_entry", {con_type, con_data}, {1'b0, 32'hFFFF_FFFB});
    @(negedge clk);
    check("int_popped", con_valid, 0);

    // Print char: only the low byte, zero-extended
    issue(32'd11, 32'h1234_5641, 1'b1);
    wait_drain("char_drain");

    // Print string "Hi" with 3-cycle memory and stalled sink
    con_ready = 1'b0;
    mem_lat = 3;
    p0 = n_pops;
    issue(32'd4, 32'h100, 1'b1);
    check("str_head", {con_valid, con_type, con_data}, {2'b11, 32'h48});
    repeat (5) @(negedge clk);
    set_ready(1'b1);
    wait_drain("str_drain");
    @(negedge clk);
    check("str_count", n_pops - p0, 2);

    // "Hello" overflows DEPTH=4: fifth byte held, unit stays stalled
    con_ready = 1'b0;
    mem_lat = 1;
    p0 = n_pops;
    issue(32'd4, 32'h200, 1'b0);
    repeat (30) @(negedge clk);
    check("full_stall", stall, 1);
    check("full_head", con_data, 32'h48);
    set_ready(1'b1);
    wait_idle("hello_idle");
    wait_drain("hello_drain");
    @(negedge clk);
    check("hello_count", n_pops - p0, 5);

    // Unterminated string: forced stop after MAXL bytes
    p0 = n_pops;
    issue(32'd4, 32'h300, 1'b1);
    wait_drain("long_drain");
    @(negedge clk);
    check("long_count", n_pops - p0, 64);
    check("long_idle", {stall, mem_req}, 2'b00);

    // Unknown service
    issue(32'd99, 32'd0, 1'b1);
    @(negedge clk);
    check("bad_set", bad_syscall, 1);
    check("bad_no_push", con_valid, 0);

    // funct 0x0C with non-zero opcode is not a syscall
    @(posedge clk); #1;
    syscall_valid = 1'b1; instruction = 32'h0800_000C; v0 = 32'd1; a0 = 32'd7;
    @(negedge clk);
    check("nonsys_stall", stall, 0);
    @(posedge clk); #1;
    syscall_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("nonsys_quiet", {stall, con_valid}, 2'b00);
    check("bad_sticky", bad_syscall, 1);

    // Async reset while waiting on memory; late ack must be ignored
    mem_manual = 1'b1;
    issue(32'd4, 32'h100, 1'b0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (mem_req) break;
    end
    repeat (2) @(negedge clk);
    check("abort_in_wait", {mem_req, stall}, 2'b11);
    reset = 1'b1;
    exp_q.delete();
    exp_bad = 1'b0;
    #1;
    check("abort_outputs", {stall, mem_req, con_valid, halted, bad_syscall}, 5'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    manual_ack = 1'b1; manual_data = 8'h55;
    @(negedge clk);
    manual_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("late_ack_ignored", {con_valid, mem_req, stall}, 3'b000);
    mem_manual = 1'b0;

    // Exit with three pending entries
    con_ready = 1'b0;
    p0 = n_pops;
    issue(32'd1, 32'd100, 1'b1);
    issue(32'd1, 32'hFFFF_FFFE, 1'b1);
    issue(32'd11, 32'h0000_005A, 1'b1);
    issue(32'd10, 32'd0, 1'b0);
    repeat (5) @(negedge clk);
    check("drain_not_halted", halted, 0);
    check("drain_stall", stall, 1);
    set_ready(1'b1);
    begin
      int k;
      for (k = 0; k < 50; k++) begin
        @(negedge clk);
        if (halted) break;
      end
      check("halt_reached", halted, 1);
      check("halt_after_pops", n_pops - p0, 3);
    end
    model_halted = 1'b1;
    issue(32'd1, 32'h77, 1'b0);
    issue(32'd99, 32'd0, 1'b0);
    repeat (5) @(negedge clk);
    check("halt_sticky", {halted, stall, con_valid, bad_syscall}, 4'b1100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
